// File: rtl/png_chunk_ctrl_if.sv
// -----------------------------------------------------------------------------
// png_chunk_ctrl_if
// One valid/ready byte stream. png_chunk_ctrl uses one instance as its payload
// input (slave side) and one as its chunk byte output (master side).
//   val  : producer has a byte on dat
//   dat  : byte being offered
//   rdy  : consumer takes the byte; a transfer happens when val && rdy
// -----------------------------------------------------------------------------
interface png_chunk_ctrl_if;
  logic       val;
  logic [7:0] dat;
  logic       rdy;

  modport master (output val, output dat, input rdy);
  modport slave  (input val, input dat, output rdy);
endinterface

// File: rtl/png_chunk_ctrl.sv
// -----------------------------------------------------------------------------
// png_chunk_ctrl
// Sequences one PNG chunk onto a byte stream: 4 length bytes, 4 type bytes,
// the payload bytes, then 4 CRC bytes, all big-endian. Drives an external
// CRC32 byte engine: restarts it when a chunk starts, feeds it the type and
// payload bytes as they leave, and sends its final value as the chunk CRC.
//
// Ports
//   clk, rstn     clock, asynchronous active-low reset
//   start_i       start request, honoured only when idle
//   typ_i, len_i  chunk type / payload length, sampled with an accepted start
//   pay           payload byte stream in (val_i / dat_i / rdy_o)
//   chk           chunk byte stream out  (val_o / dat_o / rdy_i)
//   busy_o        high from the cycle after start through DONE
//   done_o        one-cycle pulse after the last CRC byte left
//   crc_start_o   restart the CRC engine on the next edge
//   crc_val_o     byte on crc_dat_o goes into the engine on the next edge
//   crc_dat_o     byte for the engine (same as the outgoing byte)
//   crc_dat_i     finished CRC from the engine
// -----------------------------------------------------------------------------
module png_chunk_ctrl #(
  parameter int LEN_WD = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic [31:0]        typ_i,
  input  logic [LEN_WD-1:0]  len_i,
  png_chunk_ctrl_if.slave    pay,
  png_chunk_ctrl_if.master   chk,
  output logic               busy_o,
  output logic               done_o,
  output logic               crc_start_o,
  output logic               crc_val_o,
  output logic [7:0]         crc_dat_o,
  input  logic [31:0]        crc_dat_i
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_TYP  = 3'd2,
    S_DAT  = 3'd3,
    S_WAIT = 3'd4,
    S_CRC  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t            state;
  logic [1:0]        idx;       // byte index within a 4-byte field
  logic [LEN_WD-1:0] cnt;       // payload bytes still to send
  logic [LEN_WD-1:0] len_r;
  logic [31:0]       typ_r;
  logic [31:0]       crc_r;
  logic [31:0]       len_word;  // length as it appears in the 4-byte field
  logic              xfer;

  // Byte idx of a 32-bit word, index 0 is the most significant byte.
  function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      2'd3:    b = w[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign len_word = 32'(len_r);

  // Output stream mux; the payload path is a combinational passthrough.
  always_comb begin
    chk.val = 1'b0;
    chk.dat = 8'h00;
    pay.rdy = 1'b0;
    case (state)
      S_LEN: begin
        chk.val = 1'b1;
        chk.dat = pick(len_word, idx);
      end
      S_TYP: begin
        chk.val = 1'b1;
        chk.dat = pick(typ_r, idx);
      end
      S_DAT: begin
        chk.val = pay.val;
        chk.dat = pay.dat;
        pay.rdy = chk.rdy;
      end
      S_CRC: begin
        chk.val = 1'b1;
        chk.dat = pick(crc_r, idx);
      end
      default: begin
        chk.val = 1'b0;
        chk.dat = 8'h00;
        pay.rdy = 1'b0;
      end
    endcase
  end

  assign xfer = chk.val & chk.rdy;

  // Only type and payload bytes are part of the chunk CRC.
  assign crc_val_o   = xfer & ((state == S_TYP) | (state == S_DAT));
  assign crc_dat_o   = chk.dat;
  // Engine restarts on the same edge that accepts the start.
  assign crc_start_o = (state == S_IDLE) & start_i;

  // Chunk sequencer: state, counters, latched fields and busy/done flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      idx    <= 2'd0;
      cnt    <= {LEN_WD{1'b0}};
      len_r  <= {LEN_WD{1'b0}};
      typ_r  <= 32'd0;
      crc_r  <= 32'd0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            typ_r  <= typ_i;
            len_r  <= len_i;
            idx    <= 2'd0;
            busy_o <= 1'b1;
            state  <= S_LEN;
          end
        end
        S_LEN: begin
          if (xfer) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              state <= S_TYP;
            end
          end
        end
        S_TYP: begin
          if (xfer) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              if (len_r != {LEN_WD{1'b0}}) begin
                cnt   <= len_r;
                state <= S_DAT;
              end else begin
                state <= S_WAIT;
              end
            end
          end
        end
        S_DAT: begin
          if (xfer) begin
            cnt <= cnt - {{(LEN_WD-1){1'b0}}, 1'b1};
            if (cnt == {{(LEN_WD-1){1'b0}}, 1'b1}) begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Engine has absorbed the last byte; its result is valid now.
          crc_r <= crc_dat_i;
          idx   <= 2'd0;
          state <= S_CRC;
        end
        S_CRC: begin
          if (xfer) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              done_o <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_png_chunk_ctrl.sv
// -----------------------------------------------------------------------------
// tb_png_chunk_ctrl
// Directed bench for png_chunk_ctrl with a behavioural CRC32 byte engine.
// A table of chunk vectors is run without stalls; further sequences cover
// backpressure/bubbles, back-to-back starts, start while busy and reset
// mid-payload.
// -----------------------------------------------------------------------------
module tb_png_chunk_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_i;
  logic [31:0] typ_i;
  logic [31:0] len_i;
  logic        busy_o;
  logic        done_o;
  logic        crc_start_o;
  logic        crc_val_o;
  logic [7:0]  crc_dat_o;
  logic [31:0] crc_dat_i;

  png_chunk_ctrl_if pay_if ();
  png_chunk_ctrl_if chk_if ();

  png_chunk_ctrl #(.LEN_WD(32)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start_i     (start_i),
    .typ_i       (typ_i),
    .len_i       (len_i),
    .pay         (pay_if),
    .chk         (chk_if),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .crc_start_o (crc_start_o),
    .crc_val_o   (crc_val_o),
    .crc_dat_o   (crc_dat_o),
    .crc_dat_i   (crc_dat_i)
  );

  always #5 clk = ~clk;

  // Reflected CRC32 (poly 0xEDB88320), one byte.
  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'd0, b};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // External CRC engine model.
  logic [31:0] eng = 32'd0;
  always @(posedge clk) begin
    if (crc_start_o) eng <= 32'hFFFFFFFF;
    else if (crc_val_o) eng <= crc_upd(eng, crc_dat_o);
  end
  assign crc_dat_i = ~eng;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  logic [7:0] pay_mem [0:255];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int         start_cyc [$];

  function automatic logic [31:0] sw_crc(input logic [31:0] typ, input int len);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) c = crc_upd(c, typ[31-8*i -: 8]);
    for (int i = 0; i < len; i++) c = crc_upd(c, pay_mem[i]);
    return ~c;
  endfunction

  // Append one chunk's expected bytes; crc_fix != 0 gives the hand value.
  task automatic build_exp(input logic [31:0] typ, input int len, input logic [31:0] crc_fix);
    logic [31:0] l32;
    logic [31:0] crc;
    l32 = 32'(len);
    crc = (crc_fix != 32'd0) ? crc_fix : sw_crc(typ, len);
    for (int i = 0; i < 4; i++) exp_q.push_back(l32[31-8*i -: 8]);
    for (int i = 0; i < 4; i++) exp_q.push_back(typ[31-8*i -: 8]);
    for (int i = 0; i < len; i++) exp_q.push_back(pay_mem[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(crc[31-8*i -: 8]);
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_nbytes"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_val_o"},       64'(chk_if.val),  64'd0);
    check({tag, "_rdy_o"},       64'(pay_if.rdy),  64'd0);
    check({tag, "_dat_o"},       64'(chk_if.dat),  64'd0);
    check({tag, "_busy_o"},      64'(busy_o),      64'd0);
    check({tag, "_done_o"},      64'(done_o),      64'd0);
    check({tag, "_crc_start_o"}, 64'(crc_start_o), 64'd0);
    check({tag, "_crc_val_o"},   64'(crc_val_o),   64'd0);
    check({tag, "_crc_dat_o"},   64'(crc_dat_o),   64'd0);
  endtask

  // Runs one chunk (or two with hold). Outputs are sampled on the falling edge.
  task automatic run_chunk(input logic [31:0] typ, input int len, input bit stall,
                           input bit hold, input logic [31:0] typ2, input int len2,
                           input bit poke, input int rst_at,
                           output int done_cyc, output int ncrcv);
    int         cyc;
    int         pidx;
    int         ndone;
    int         nwant;
    bit         held_v;
    logic [7:0] held;
    bit         keep;
    bit         poked;
    got_q.delete();
    start_cyc.delete();
    ncrcv = 0; done_cyc = -1; ndone = 0; pidx = 0;
    held_v = 1'b0; held = 8'h00; keep = 1'b0; poked = 1'b0;
    nwant = hold ? 2 : 1;
    @(posedge clk); #1;
    start_i = 1'b1; typ_i = typ; len_i = 32'(len);
    cyc = 0;
    while (cyc < 3000) begin
      if (!keep) pay_if.val = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      pay_if.dat = pay_if.val ? pay_mem[pidx[7:0]] : 8'h5A;
      chk_if.rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (crc_start_o) start_cyc.push_back(cyc);
      if (crc_val_o) ncrcv++;
      if (held_v) begin
        check("stall_hold_val", 64'(chk_if.val), 64'd1);
        check("stall_hold_dat", 64'(chk_if.dat), 64'(held));
      end
      held_v = chk_if.val && !chk_if.rdy;
      held   = chk_if.dat;
      if (chk_if.val && chk_if.rdy) got_q.push_back(chk_if.dat);
      keep = pay_if.val && !pay_if.rdy;
      if (pay_if.val && pay_if.rdy) pidx++;
      if (done_o) begin
        ndone++;
        if (ndone == 1) done_cyc = cyc;
      end
      if (rst_at >= 0 && pidx == rst_at) begin
        rstn = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_mid");
        check("rst_no_done", 64'(ndone), 64'd0);
        rstn = 1'b1;
        return;
      end
      if (ndone == nwant) break;
      @(posedge clk); #1;
      cyc++;
      if (hold && start_cyc.size() < 2) begin
        start_i = 1'b1; typ_i = typ2; len_i = 32'(len2);
      end else if (poke && !poked && pidx == 3) begin
        start_i = 1'b1; typ_i = 32'hDEADBEEF; len_i = 32'd7; poked = 1'b1;
      end else begin
        start_i = 1'b0;
      end
    end
    check("chunk_timeout_dones", 64'(ndone), 64'(nwant));
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check("post_done_busy", 64'(busy_o), 64'd0);
    check("post_done_val",  64'(chk_if.val), 64'd0);
  endtask

  typedef struct {
    logic [31:0] typ;
    int          len;
    logic [31:0] crc;      // 0: take CRC from the software model
    int          done_cyc;
    int          ncrcv;
  } vec_t;

  vec_t vt [4];

  initial begin
    int dc;
    int nc;
    logic [7:0] ihdr [0:12];

    ihdr = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
             8'h08, 8'h02, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 256; i++) pay_mem[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 13; i++) pay_mem[i] = ihdr[i];

    vt[0] = '{32'h49454E44,   0, 32'hAE426082,  14,   4};
    vt[1] = '{32'h49484452,  13, 32'h907753DE,  27,  17};
    vt[2] = '{32'h49444154,   1, 32'h00000000,  15,   5};
    vt[3] = '{32'h49444154, 100, 32'h00000000, 114, 104};

    rstn = 1'b0; start_i = 1'b0; typ_i = 32'd0; len_i = 32'd0;
    pay_if.val = 1'b0; pay_if.dat = 8'h00; chk_if.rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rstn = 1'b1;

    // Table of chunks, no stalls.
    for (int v = 0; v < 4; v++) begin
      exp_q.delete();
      build_exp(vt[v].typ, vt[v].len, vt[v].crc);
      run_chunk(vt[v].typ, vt[v].len, 1'b0, 1'b0, 32'd0, 0, 1'b0, -1, dc, nc);
      cmp_stream($sformatf("vec%0d", v));
      check($sformatf("vec%0d_done_cyc", v), 64'(dc), 64'(vt[v].done_cyc));
      check($sformatf("vec%0d_crc_val_cnt", v), 64'(nc), 64'(vt[v].ncrcv));
      check($sformatf("vec%0d_crc_start_cnt", v), 64'(start_cyc.size()), 64'd1);
      if (start_cyc.size() > 0)
        check($sformatf("vec%0d_crc_start_cyc", v), 64'(start_cyc[0]), 64'd0);
    end

    // 100-byte chunk with random backpressure and payload bubbles.
    exp_q.delete();
    build_exp(32'h49444154, 100, 32'd0);
    run_chunk(32'h49444154, 100, 1'b1, 1'b0, 32'd0, 0, 1'b0, -1, dc, nc);
    cmp_stream("stall");
    check("stall_crc_val_cnt", 64'(nc), 64'd104);
    check("stall_crc_start_cnt", 64'(start_cyc.size()), 64'd1);

    // IHDR then IEND with start held high.
    exp_q.delete();
    build_exp(32'h49484452, 13, 32'h907753DE);
    build_exp(32'h49454E44, 0, 32'hAE426082);
    run_chunk(32'h49484452, 13, 1'b0, 1'b1, 32'h49454E44, 0, 1'b0, -1, dc, nc);
    cmp_stream("b2b");
    check("b2b_first_done_cyc", 64'(dc), 64'd27);
    check("b2b_crc_start_cnt", 64'(start_cyc.size()), 64'd2);
    if (start_cyc.size() > 1)
      check("b2b_second_start_cyc", 64'(start_cyc[1]), 64'd28);
    check("b2b_crc_val_cnt", 64'(nc), 64'd21);

    // Start pulse with other type/length while in DAT.
    exp_q.delete();
    build_exp(32'h49444154, 20, 32'd0);
    run_chunk(32'h49444154, 20, 1'b0, 1'b0, 32'd0, 0, 1'b1, -1, dc, nc);
    cmp_stream("poke");
    check("poke_done_cyc", 64'(dc), 64'd34);
    check("poke_crc_start_cnt", 64'(start_cyc.size()), 64'd1);

    // Reset at payload byte 5, then a clean IEND.
    run_chunk(32'h49444154, 10, 1'b0, 1'b0, 32'd0, 0, 1'b0, 5, dc, nc);
    check("rst_done_cyc", 64'(dc), 64'hFFFFFFFFFFFFFFFF);
    exp_q.delete();
    build_exp(32'h49454E44, 0, 32'hAE426082);
    run_chunk(32'h49454E44, 0, 1'b0, 1'b0, 32'd0, 0, 1'b0, -1, dc, nc);
    cmp_stream("after_rst");
    check("after_rst_done_cyc", 64'(dc), 64'd14);
    check("after_rst_crc_val_cnt", 64'(nc), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
